hazard_scoreboard: RTL and testbench

Parametrised data-hazard unit for the pipelined RV32 core. It replaces fixed EX/MEM/WB compare logic with an internal scoreboard shift pipeline of in-flight register writers. The scoreboard has NSTAGE entries and serves NRP read ports. For each read port it selects the youngest forwarding source, and it raises a stall whenever the matching writer's data is not yet available (generalised load-use). It sits beside the ID stage, driving the IF/ID and PC hold and the ID/EX bubble.

---
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: tracks in-flight RF writers after ID, selects the youngest bypass
// source per read port and raises a load-use/interlock stall. Macro HAZ_FORWARD_EN enables bypass.
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int NRP        = 2,
  parameter int NSTAGE     = 3,
  parameter int LOAD_READY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic                        id_we,
  input  logic                        id_load,
  input  logic [4:0]                  id_rd,
  input  logic [NRP*5-1:0]            id_rs,
  input  logic [NRP-1:0]              id_rs_used,
  input  logic [NRP*XLEN-1:0]         id_rf_data,
  input  logic [NSTAGE*XLEN-1:0]      stage_wd,
  input  logic                        flush,
  output logic                        stall,
  output logic [NRP*XLEN-1:0]         fwd_data,
  output logic [NRP-1:0]              fwd_hit,
  output logic [$clog2(NSTAGE+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]      valid_q, valid_d;
  logic [NSTAGE-1:0]      we_q, we_d;
  logic [NSTAGE-1:0]      load_q, load_d;
  logic [NSTAGE-1:0][4:0] rd_q, rd_d;
  logic [OCC_W-1:0]       occupancy_q, occupancy_d;

  logic                   stall_s;
  logic                   accept_s;
  logic [NRP-1:0]         not_ready_s;
  logic [NRP-1:0]         fwd_hit_s;
  logic [NRP*XLEN-1:0]    fwd_data_s;

  function automatic logic [OCC_W-1:0] popcount(input logic [NSTAGE-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      c = c + OCC_W'(v[k]);
    end
    return c;
  endfunction

  // Per-port youngest-writer search, readiness and bypass mux.
  always_comb begin
    logic found;
`ifdef HAZ_FORWARD_EN
    int   win_k;
`endif
    not_ready_s = '0;
    fwd_hit_s   = '0;
    fwd_data_s  = id_rf_data;
    for (int p = 0; p < NRP; p++) begin
      found = 1'b0;
`ifdef HAZ_FORWARD_EN
      win_k = 0;
`endif
      // Scan oldest to youngest so the lowest matching stage is the one kept.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (id_valid && id_rs_used[p] && valid_q[k] && we_q[k] &&
            (rd_q[k] == id_rs[5*p +: 5]) && (id_rs[5*p +: 5] != 5'd0)) begin
          found = 1'b1;
`ifdef HAZ_FORWARD_EN
          win_k = k;
`endif
        end else begin
          found = found;
        end
      end
      if (found) begin
`ifdef HAZ_FORWARD_EN
        if (load_q[win_k] && (win_k < LOAD_READY)) begin
          not_ready_s[p] = 1'b1;
        end else begin
          fwd_hit_s[p]              = 1'b1;
          fwd_data_s[p*XLEN +: XLEN] = stage_wd[win_k*XLEN +: XLEN];
        end
`else
        not_ready_s[p] = 1'b1;
`endif
      end else begin
        not_ready_s[p] = 1'b0;
      end
    end
  end

`ifndef HAZ_FORWARD_EN
  logic unused_ok_s;
  assign unused_ok_s = ^{stage_wd, load_q};
`endif

  // Stall gating; flush and an empty ID slot both suppress it.
  always_comb begin
    stall_s  = id_valid & ~flush & (|not_ready_s);
    accept_s = id_valid & ~flush & ~stall_s;
  end

  // Next scoreboard contents: shift down, new writer or bubble into entry 0.
  always_comb begin
    valid_d = '0;
    we_d    = '0;
    load_d  = '0;
    rd_d    = '0;
    if (accept_s && id_we && (id_rd != 5'd0)) begin
      valid_d[0] = 1'b1;
      we_d[0]    = 1'b1;
      load_d[0]  = id_load;
      rd_d[0]    = id_rd;
    end else begin
      valid_d[0] = 1'b0;
      we_d[0]    = 1'b0;
      load_d[0]  = 1'b0;
      rd_d[0]    = 5'd0;
    end
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      we_d[k]    = we_q[k-1];
      load_d[k]  = load_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    occupancy_d = popcount(valid_d);
  end

  // Scoreboard and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      we_q        <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign stall     = stall_s;
  assign fwd_hit   = fwd_hit_s;
  assign fwd_data  = fwd_data_s;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; expectations follow HAZ_FORWARD_EN.
module tb_hazard_scoreboard;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_we, id_load, flush;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [63:0] id_rf_data;
  logic [95:0] stage_wd;
  logic        stall;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_hit;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  occ;
  } exp_t;
  exp_t q[$];

  localparam logic [31:0] RF0 = 32'h0000_AAAA;
  localparam logic [31:0] RF1 = 32'h0000_BBBB;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_we(id_we), .id_load(id_load),
    .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rf_data(id_rf_data),
    .stage_wd(stage_wd), .flush(flush), .stall(stall), .fwd_data(fwd_data),
    .fwd_hit(fwd_hit), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic fl);
    id_valid = v; id_we = we; id_load = ld; id_rd = rd;
    id_rs = {rs1, rs0}; id_rs_used = used; flush = fl;
  endtask

  task automatic wdata(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    stage_wd = {w2, w1, w0};
  endtask

  task automatic push(input string tag, input logic st, input logic [1:0] hit,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] occ);
    exp_t e;
    e.tag = tag; e.st = st; e.hit = hit; e.d0 = d0; e.d1 = d1; e.occ = occ;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    e = q.pop_front();
    tests++;
    assert (stall === e.st) else begin
      fails++; $error("FAIL %s.stall observed=%0h expected=%0h", e.tag, stall, e.st);
    end
    tests++;
    assert (fwd_hit === e.hit) else begin
      fails++; $error("FAIL %s.fwd_hit observed=%0h expected=%0h", e.tag, fwd_hit, e.hit);
    end
    tests++;
    assert (fwd_data[31:0] === e.d0) else begin
      fails++; $error("FAIL %s.fwd_data0 observed=%0h expected=%0h", e.tag, fwd_data[31:0], e.d0);
    end
    tests++;
    assert (fwd_data[63:32] === e.d1) else begin
      fails++; $error("FAIL %s.fwd_data1 observed=%0h expected=%0h", e.tag, fwd_data[63:32], e.d1);
    end
    tests++;
    assert (occupancy === e.occ) else begin
      fails++; $error("FAIL %s.occupancy observed=%0h expected=%0h", e.tag, occupancy, e.occ);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_rf_data = {RF1, RF0};
    wdata(32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b11, 1'b0);
    push("reset", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    rst_n = 1'b1;

    // ALU write x5 then dependent read on port 0
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    push("alu_wr", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
    wdata(32'h1234, 32'h9999, 32'h8888);
    push("alu_use_ex", ~FWD, {1'b0, FWD}, FWD ? 32'h1234 : RF0, RF1, 2'd1);
    cyc();
    wdata(32'h7777, 32'h1234, 32'h8888);
    push("alu_use_mem", ~FWD, {1'b0, FWD}, FWD ? 32'h1234 : RF0, RF1, 2'd1);
    cyc();
    wdata(32'h7777, 32'h9999, 32'h1234);
    push("alu_use_wb", ~FWD, {1'b0, FWD}, FWD ? 32'h1234 : RF0, RF1, 2'd1);
    cyc();
    push("alu_use_rf", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();

    // Load x6 then immediate dependent read on port 1
    drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0);
    push("ld_wr", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 2'b10, 1'b0);
    wdata(32'h1111, 32'h2222, 32'h3333);
    push("ld_use_ex", 1'b1, 2'b00, RF0, RF1, 2'd1);
    cyc();
    wdata(32'h1111, 32'hCAFE_F00D, 32'h3333);
    push("ld_use_mem", ~FWD, {FWD, 1'b0}, RF0, FWD ? 32'hCAFE_F00D : RF1, 2'd1);
    cyc();
    wdata(32'h1111, 32'h2222, 32'hCAFE_F00D);
    push("ld_use_wb", ~FWD, {FWD, 1'b0}, RF0, FWD ? 32'hCAFE_F00D : RF1, 2'd1);
    cyc();

    // x7 in EX and WB; both ports read x7
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    push("y_wr_a", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    push("y_idle", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    push("y_wr_b", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 2'b11, 1'b0);
    wdata(32'h1, 32'h55, 32'h2);
    push("y_youngest", ~FWD, {FWD, FWD}, FWD ? 32'h1 : RF0, FWD ? 32'h1 : RF1, 2'd2);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 2'b11, 1'b0);
    push("y_novalid", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    push("y_drain", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();

    // rd=0 and we=0 writers are never tracked
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    push("z_wr_x0", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 2'b01, 1'b0);
    wdata(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push("z_rd_x0", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01, 1'b0);
    push("z_rd_nowe", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();

    // Load-use with flush in the same cycle
    drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0);
    push("f_ld", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd6, 2'b10, 1'b1);
    wdata(32'h1111, 32'h2222, 32'h3333);
    push("f_flush", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    push("f_after", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    push("f_drain1", 1'b0, 2'b00, RF0, RF1, 2'd1);
    cyc();
    push("f_drain2", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();

    // Reset asserted mid-hazard
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd0, 5'd0, 2'b00, 1'b0);
    push("r_wr", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0, 2'b01, 1'b0);
    wdata(32'h4242, 32'h0, 32'h0);
    push("r_use", ~FWD, {1'b0, FWD}, FWD ? 32'h4242 : RF0, RF1, 2'd1);
    @(negedge clk);
    check();
    #1 rst_n = 1'b0;
    #1;
    push("r_async", 1'b0, 2'b00, RF0, RF1, 2'd0);
    check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("r_after", 1'b0, 2'b00, RF0, RF1, 2'd0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
